// File: rtl/rf_write_scheduler_if.sv
// Multi-cycle result offer channel into the write scheduler.
//   mc_valid : result offered this cycle
//   mc_wa    : destination register of the offered result
//   mc_wd    : result data
//   mc_ready : scheduler can accept a result this cycle
// master = multi-cycle execution unit, slave = rf_write_scheduler.
interface rf_write_scheduler_if;
    logic        mc_valid;
    logic [4:0]  mc_wa;
    logic [31:0] mc_wd;
    logic        mc_ready;

    modport master (output mc_valid, output mc_wa, output mc_wd, input mc_ready);
    modport slave  (input mc_valid, input mc_wa, input mc_wd, output mc_ready);
endinterface

// File: rtl/rf_write_scheduler.sv
// Arbitrates the register file's single write port between the in-order
// writeback stage (always wins) and a FIFO of out-of-band multi-cycle
// results. Keeps a busy scoreboard of outstanding multi-cycle destinations
// for decode hazard checks and forces a stall when the FIFO head starves.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_wb_we/wa/wd           pipeline writeback request (never back-pressured)
//   mc                      multi-cycle result offer (slave modport)
//   i_iss_valid, i_iss_rd   multi-cycle op issued with destination
//   i_chk_ra1/ra2/wa        decode-stage registers to hazard-check
//   o_stall                 decode must hold (hazard or starvation)
//   o_rf_we/wa/wd           register file write port
//   o_busy                  scoreboard, bit 0 always 0
module rf_write_scheduler #(
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wb_we,
    input  logic [4:0]           i_wb_wa,
    input  logic [31:0]          i_wb_wd,
    rf_write_scheduler_if.slave  mc,
    input  logic                 i_iss_valid,
    input  logic [4:0]           i_iss_rd,
    input  logic [4:0]           i_chk_ra1,
    input  logic [4:0]           i_chk_ra2,
    input  logic [4:0]           i_chk_wa,
    output logic                 o_stall,
    output logic                 o_rf_we,
    output logic [4:0]           o_rf_wa,
    output logic [31:0]          o_rf_wd,
    output logic [31:0]          o_busy
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_mem_wa [QDEPTH];
    logic [31:0]   r_mem_wd [QDEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_busy;
    logic [SW-1:0] r_starve_cnt;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_wb_req;
    logic        w_pop;
    logic        w_starve;
    logic        w_hazard;
    logic [4:0]  w_head_wa;
    logic [31:0] w_head_wd;
    logic [31:0] w_busy_nxt;

    assign w_full    = (r_count == CW'(QDEPTH));
    assign w_empty   = (r_count == '0);
    assign w_head_wa = r_mem_wa[r_rd_ptr];
    assign w_head_wd = r_mem_wd[r_rd_ptr];

    // Ready is derived from the pre-pop count, so a pop while full never
    // makes room for a same-cycle push.
    assign mc.mc_ready = !w_full && !i_rst;
    assign w_accept    = mc.mc_valid && mc.mc_ready;
    // Results for x0 are acknowledged but dropped.
    assign w_push      = w_accept && (mc.mc_wa != 5'd0);

    // Outputs are forced idle while in reset regardless of stale state.
    assign w_wb_req = i_wb_we && (i_wb_wa != 5'd0) && !i_rst;
    assign w_pop    = !w_wb_req && !w_empty && !i_rst;

    always_comb begin
        o_rf_we = 1'b0;
        o_rf_wa = 5'd0;
        o_rf_wd = 32'd0;
        if (w_wb_req) begin
            o_rf_we = 1'b1;
            o_rf_wa = i_wb_wa;
            o_rf_wd = i_wb_wd;
        end else if (w_pop) begin
            o_rf_we = 1'b1;
            o_rf_wa = w_head_wa;
            o_rf_wd = w_head_wd;
        end
    end

    assign w_starve = (r_starve_cnt == SW'(STARVE_LIMIT));
    assign w_hazard = r_busy[i_chk_ra1] | r_busy[i_chk_ra2] | r_busy[i_chk_wa];
    assign o_stall  = (w_hazard | w_starve) && !i_rst;
    assign o_busy   = i_rst ? 32'd0 : r_busy;

    // Clear before set so a same-cycle reissue of the popped register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_wa] = 1'b0;
        end
        if (i_iss_valid && (i_iss_rd != 5'd0)) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_wa[r_wr_ptr] <= mc.mc_wa;
            r_mem_wd[r_wr_ptr] <= mc.mc_wd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_busy       <= 32'd0;
            r_starve_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Only a writeback can keep a non-empty head from popping.
            if (w_empty || w_pop) begin
                r_starve_cnt <= '0;
            end else if (!w_starve) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_ra1, chk_ra2, chk_wa;
    logic        stall, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    rf_write_scheduler_if u_if ();

    rf_write_scheduler #(.QDEPTH(2), .STARVE_LIMIT(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wb_we     (wb_we),
        .i_wb_wa     (wb_wa),
        .i_wb_wd     (wb_wd),
        .mc          (u_if),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .i_chk_ra1   (chk_ra1),
        .i_chk_ra2   (chk_ra2),
        .i_chk_wa    (chk_wa),
        .o_stall     (stall),
        .o_rf_we     (rf_we),
        .o_rf_wa     (rf_wa),
        .o_rf_wd     (rf_wd),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wb_we;
        logic [4:0]  wb_wa;
        logic [31:0] wb_wd;
        logic        mc_valid;
        logic [4:0]  mc_wa;
        logic [31:0] mc_wd;
        logic        iss_valid;
        logic [4:0]  iss_rd;
        logic [4:0]  ra1, ra2, cwa;
        logic        e_ready;
        logic        e_stall;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int r, input int we, input int wa, input int wd,
                       input int mv, input int mwa, input int mwd,
                       input int iv, input int ird,
                       input int a1, input int a2, input int cw,
                       input int er, input int es, input int ewe,
                       input int ewa, input int ewd, input int eb);
        vec_t v;
        v.rst = 1'(r);        v.wb_we = 1'(we);     v.wb_wa = 5'(wa);   v.wb_wd = 32'(wd);
        v.mc_valid = 1'(mv);  v.mc_wa = 5'(mwa);    v.mc_wd = 32'(mwd);
        v.iss_valid = 1'(iv); v.iss_rd = 5'(ird);
        v.ra1 = 5'(a1);       v.ra2 = 5'(a2);       v.cwa = 5'(cw);
        v.e_ready = 1'(er);   v.e_stall = 1'(es);   v.e_we = 1'(ewe);
        v.e_wa = 5'(ewa);     v.e_wd = 32'(ewd);    v.e_busy = 32'(eb);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst;
        wb_we = v.wb_we; wb_wa = v.wb_wa; wb_wd = v.wb_wd;
        u_if.mc_valid = v.mc_valid; u_if.mc_wa = v.mc_wa; u_if.mc_wd = v.mc_wd;
        iss_valid = v.iss_valid; iss_rd = v.iss_rd;
        chk_ra1 = v.ra1; chk_ra2 = v.ra2; chk_wa = v.cwa;
    endtask

    task automatic idle();
        rst = 1'b0;
        wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'd0;
        u_if.mc_valid = 1'b0; u_if.mc_wa = 5'd0; u_if.mc_wd = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
        chk_ra1 = 5'd0; chk_ra2 = 5'd0; chk_wa = 5'd0;
    endtask

    task automatic check_rf(input string tag, input logic ewe, input logic [4:0] ewa,
                            input logic [31:0] ewd);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(ewe));
        if (ewe) begin
            chk({tag, ".rf_wa"}, 32'(rf_wa), 32'(ewa));
            chk({tag, ".rf_wd"}, rf_wd, ewd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;

        //   rst wb(we,wa,wd)       mc(v,wa,wd)           iss    ra1 ra2 wa  rdy stl we wa wd           busy
        add(1,  1, 3, 'h1,        1, 4, 'h5,            0, 0,  0, 0, 0,   0, 0, 0, 0, 0,           0);
        add(1,  1, 3, 'h1,        1, 4, 'h5,            0, 0,  0, 0, 0,   0, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          0, 0, 0,              1, 5,  5, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  5, 0, 0,   1, 1, 0, 0, 0,           'h20);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  5, 0, 0,   1, 1, 0, 0, 0,           'h20);
        add(0,  0, 0, 0,          1, 5, 'hDEADBEEF,     0, 0,  5, 0, 0,   1, 1, 0, 0, 0,           'h20);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  5, 0, 0,   1, 1, 1, 5, 'hDEADBEEF,  'h20);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  5, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  1, 3, 'h22,       1, 7, 'h11,           1, 7,  0, 0, 0,   1, 0, 1, 3, 'h22,        0);
        add(0,  1, 3, 'h22,       0, 0, 0,              0, 0,  0, 0, 7,   1, 1, 1, 3, 'h22,        'h80);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 0, 7,   1, 1, 1, 7, 'h11,        'h80);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 0, 7,   1, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          1, 0, 'h33,           1, 0,  0, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          1, 10, 'hAA,          0, 0,  0, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  1, 0, 'h55,       0, 0, 0,              0, 0,  0, 0, 0,   1, 0, 1, 10, 'hAA,       0);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          0, 0, 0,              1, 9,  0, 0, 0,   1, 0, 0, 0, 0,           0);
        add(0,  0, 0, 0,          1, 9, 'h77,           0, 0,  0, 9, 0,   1, 1, 0, 0, 0,           'h200);
        add(0,  0, 0, 0,          0, 0, 0,              1, 9,  0, 9, 0,   1, 1, 1, 9, 'h77,        'h200);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 9, 0,   1, 1, 0, 0, 0,           'h200);
        add(0,  0, 0, 0,          1, 9, 'h78,           0, 0,  0, 9, 0,   1, 1, 0, 0, 0,           'h200);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 9, 0,   1, 1, 1, 9, 'h78,        'h200);
        add(0,  0, 0, 0,          0, 0, 0,              0, 0,  0, 9, 0,   1, 0, 0, 0, 0,           0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk({tag, ".mc_ready"}, 32'(u_if.mc_ready), 32'(vecs[i].e_ready));
            chk({tag, ".stall"}, 32'(stall), 32'(vecs[i].e_stall));
            chk({tag, ".busy"}, busy, vecs[i].e_busy);
            check_rf(tag, vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd);
        end

        // Fill the FIFO behind a continuous writeback, observe back-pressure
        // and starvation, then drain one entry per cycle.
        @(negedge clk); idle();
        wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h100;
        u_if.mc_valid = 1'b1; u_if.mc_wa = 5'd20; u_if.mc_wd = 32'hA0;
        #1;
        chk("full0.mc_ready", 32'(u_if.mc_ready), 32'd1);
        check_rf("full0", 1'b1, 5'd1, 32'h100);

        @(negedge clk);
        u_if.mc_wa = 5'd21; u_if.mc_wd = 32'hA1;
        #1;
        chk("full1.mc_ready", 32'(u_if.mc_ready), 32'd1);
        chk("full1.stall", 32'(stall), 32'd0);

        @(negedge clk);
        u_if.mc_wa = 5'd22; u_if.mc_wd = 32'hA2;
        #1;
        chk("full2.mc_ready", 32'(u_if.mc_ready), 32'd0);
        chk("full2.stall", 32'(stall), 32'd0);
        check_rf("full2", 1'b1, 5'd1, 32'h100);

        @(negedge clk); #1;
        chk("starve3.stall", 32'(stall), 32'd0);
        @(negedge clk); #1;
        chk("starve4.stall", 32'(stall), 32'd0);
        @(negedge clk); #1;
        chk("starve5.stall", 32'(stall), 32'd1);
        chk("starve5.mc_ready", 32'(u_if.mc_ready), 32'd0);

        @(negedge clk);
        wb_we = 1'b0;
        #1;
        check_rf("drain0", 1'b1, 5'd20, 32'hA0);
        chk("drain0.mc_ready", 32'(u_if.mc_ready), 32'd0);
        chk("drain0.stall", 32'(stall), 32'd1);

        @(negedge clk); #1;
        check_rf("drain1", 1'b1, 5'd21, 32'hA1);
        chk("drain1.mc_ready", 32'(u_if.mc_ready), 32'd1);
        chk("drain1.stall", 32'(stall), 32'd0);

        @(negedge clk);
        u_if.mc_valid = 1'b0;
        #1;
        check_rf("drain2", 1'b1, 5'd22, 32'hA2);

        @(negedge clk); #1;
        check_rf("drain3", 1'b0, 5'd0, 32'd0);
        chk("drain3.busy", busy, 32'd0);

        // Reset in the middle of operation drops buffered result and scoreboard.
        @(negedge clk); idle();
        iss_valid = 1'b1; iss_rd = 5'd15;
        u_if.mc_valid = 1'b1; u_if.mc_wa = 5'd15; u_if.mc_wd = 32'h5;
        @(negedge clk); idle();
        rst = 1'b1; chk_ra1 = 5'd15;
        #1;
        check_rf("midrst", 1'b0, 5'd0, 32'd0);
        chk("midrst.busy", busy, 32'd0);
        chk("midrst.mc_ready", 32'(u_if.mc_ready), 32'd0);
        chk("midrst.stall", 32'(stall), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_rf("postrst", 1'b0, 5'd0, 32'd0);
        chk("postrst.busy", busy, 32'd0);
        chk("postrst.mc_ready", 32'(u_if.mc_ready), 32'd1);
        chk("postrst.stall", 32'(stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
